// File: rtl/alu_pkg.sv
// Shared opcode map, flag bit positions and control-state type for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b0101;
    localparam logic [3:0] OP_MOV = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SLR = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;

    localparam int F_S = 3;
    localparam int F_Z = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Opcodes 1000..1011 are the iterative shift/rotate group.
    function automatic logic is_shift(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle add/sub/logic/move/compare unit; shift opcodes fall to the default (zero) arm.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    output logic [WIDTH-1:0] res_o,
    output logic [3:0]       szcv_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] flag_src;

    always_comb begin
        sum    = {1'b0, a_i} + {1'b0, b_i};
        diff   = {1'b0, b_i} - {1'b0, a_i};
        res_o  = '0;
        szcv_o = '0;
        case (op_i)
            OP_ADD: begin
                res_o       = sum[WIDTH-1:0];
                szcv_o[F_C] = sum[WIDTH];
                szcv_o[F_V] = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                res_o       = (op_i == OP_CMP) ? b_i : diff[WIDTH-1:0];
                szcv_o[F_C] = diff[WIDTH];
                szcv_o[F_V] = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != b_i[WIDTH-1]);
            end
            OP_AND: res_o = a_i & b_i;
            OP_OR:  res_o = a_i | b_i;
            OP_XOR: res_o = a_i ^ b_i;
            OP_MOV: res_o = a_i;
            default: res_o = '0;
        endcase
        // CMP returns b unchanged but reports sign/zero of the difference.
        flag_src    = (op_i == OP_CMP) ? diff[WIDTH-1:0] : res_o;
        szcv_o[F_S] = flag_src[WIDTH-1];
        szcv_o[F_Z] = (flag_src == '0);
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops via alu_comb, shifts/rotates one bit per cycle,
// result held until consumed, flags committed on each output transfer.
//   state | meaning
//   IDLE  | ready for a new operation
//   SHIFT | iterating a shift/rotate, one bit per edge
//   DONE  | result valid, waiting for out_ready
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       szcv,
    output logic [3:0]       flags,
    output logic             busy
);

    state_e           state_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] res_q;
    logic [SHW-1:0]   cnt_q;
    logic [1:0]       sh_op_q;
    logic [3:0]       szcv_q;
    logic [3:0]       flags_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] comb_res;
    logic [3:0]       comb_szcv;
    logic [WIDTH-1:0] work_d;
    logic             c_d;
    logic [SHW-1:0]   k;

    assign k = b[SHW-1:0];

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .a_i    (a),
        .b_i    (b),
        .op_i   (op),
        .res_o  (comb_res),
        .szcv_o (comb_szcv)
    );

    // One-bit step of the latched shift type; c_d is the bit leaving the word.
    always_comb begin
        work_d = work_q;
        c_d    = 1'b0;
        case (sh_op_q)
            2'b00: begin work_d = {work_q[WIDTH-2:0], 1'b0};           c_d = work_q[WIDTH-1]; end
            2'b01: begin work_d = {work_q[WIDTH-2:0], work_q[WIDTH-1]}; c_d = work_q[WIDTH-1]; end
            2'b10: begin work_d = {1'b0, work_q[WIDTH-1:1]};           c_d = work_q[0];       end
            default: begin work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]}; c_d = work_q[0];   end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            sh_op_q     <= '0;
            szcv_q      <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (is_shift(op) && k != '0) begin
                            work_q  <= a;
                            cnt_q   <= k;
                            sh_op_q <= op[1:0];
                            state_q <= ST_SHIFT;
                        end else begin
                            if (is_shift(op)) begin
                                res_q  <= a;
                                szcv_q <= {a[WIDTH-1], a == '0, 2'b00};
                            end else begin
                                res_q  <= comb_res;
                                szcv_q <= comb_szcv;
                            end
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        res_q       <= work_d;
                        szcv_q      <= {work_d[WIDTH-1], work_d == '0, c_d, 1'b0};
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        flags_q     <= szcv_q;
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign szcv      = szcv_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=16) with an arithmetic reference model and scoreboard.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] a, b, res;
    logic [3:0]  op, szcv, flags;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [15:0] r;
        logic [3:0]  f;
    } exp_t;

    exp_t       expq[$];
    logic [3:0] exp_flags;

    seq_alu #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .szcv      (szcv),
        .flags     (flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Reference model in plain integer arithmetic.
    function automatic exp_t model_out(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t        e;
        int          ux, uy, sx, sy, t, k;
        logic [15:0] r, fr;
        logic        c, v;
        ux = x; uy = y; sx = $signed(x); sy = $signed(y);
        k = y[3:0];
        c = 1'b0; v = 1'b0; r = '0;
        case (o)
            4'h0: begin t = ux + uy; r = t[15:0]; c = (t > 65535); v = (sx + sy > 32767) || (sx + sy < -32768); end
            4'h1, 4'h5: begin
                t = uy - ux; r = t[15:0]; c = (uy < ux);
                v = (sy - sx > 32767) || (sy - sx < -32768);
            end
            4'h2: r = x & y;
            4'h3: r = x | y;
            4'h4: r = x ^ y;
            4'h6: r = x;
            4'h8: begin r = x << k; c = (k > 0) ? x[16-k] : 1'b0; end
            4'h9: begin r = (k > 0) ? ((x << k) | (x >> (16 - k))) : x; c = (k > 0) ? r[0] : 1'b0; end
            4'hA: begin r = x >> k; c = (k > 0) ? x[k-1] : 1'b0; end
            4'hB: begin r = $signed(x) >>> k; c = (k > 0) ? x[k-1] : 1'b0; end
            default: r = '0;
        endcase
        fr = r;
        if (o == 4'h5) r = y;
        e.r = r;
        e.f = {fr[15], fr == 16'h0, c, v};
        return e;
    endfunction

    function automatic int model_lat(input logic [3:0] o, input logic [15:0] y);
        if (o[3:2] == 2'b10 && y[3:0] != 4'h0) return 1 + int'(y[3:0]);
        return 1;
    endfunction

    // Scoreboard: compares held outputs and committed flags every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            check("flags", flags, exp_flags);
            if (out_valid) begin
                check("out_valid_pending", expq.size(), 1);
                if (expq.size() > 0) begin
                    check("res", res, expq[0].r);
                    check("szcv", szcv, expq[0].f);
                end
            end
            if (rst) begin
                expq.delete();
                exp_flags = 4'h0;
            end else begin
                if (out_valid && out_ready && expq.size() > 0) begin
                    exp_flags = expq[0].f;
                    void'(expq.pop_front());
                end
                if (in_valid && in_ready) begin
                    e = model_out(op, a, b);
                    expq.push_back(e);
                end
            end
        end
    end

    task automatic do_op(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                         input int hold, output logic [15:0] r, output logic [3:0] f);
        int lat;
        int wt;
        wt = 0;
        while (!in_ready && wt < 50) begin @(posedge clk); #1; wt++; end
        check("in_ready_before", in_ready, 1);
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); op = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check("latency", lat, model_lat(o, y));
        r = res; f = szcv;
        for (int i = 0; i < hold; i++) begin
            check("in_ready_held", in_ready, 0);
            check("busy_held", busy, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after", in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] r;
        logic [3:0]  f;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        exp_flags = 4'h0;
        @(posedge clk); #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_res", res, 0);
        check("rst_szcv", szcv, 0);
        check("rst_flags", flags, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        chk_en = 1'b1;

        do_op(4'h0, 16'h7FFF, 16'h0001, 0, r, f);
        check("add_res", r, 16'h8000); check("add_szcv", f, 4'b1001);
        check("add_flags", flags, 4'b1001);
        do_op(4'h1, 16'h0005, 16'h0003, 0, r, f);
        check("sub_res", r, 16'hFFFE); check("sub_szcv", f, 4'b1010);
        do_op(4'h5, 16'h0003, 16'h0003, 0, r, f);
        check("cmp_res", r, 16'h0003); check("cmp_szcv", f, 4'b0100);
        do_op(4'h8, 16'h8001, 16'h0004, 0, r, f);
        check("sll_res", r, 16'h0010); check("sll_szcv", f, 4'b0000);
        do_op(4'h9, 16'h8001, 16'h0001, 0, r, f);
        check("slr_res", r, 16'h0003); check("slr_szcv", f, 4'b0010);
        do_op(4'hB, 16'h8000, 16'h000F, 0, r, f);
        check("sra_res", r, 16'hFFFF); check("sra_szcv", f, 4'b1000);
        do_op(4'h8, 16'h8234, 16'h0010, 0, r, f);
        check("k0_res", r, 16'h8234); check("k0_szcv", f, 4'b1000);

        do_op(4'h0, 16'h0001, 16'h0002, 3, r, f);
        check("bp_res", r, 16'h0003); check("bp_flags", flags, 4'b0000);

        op = 4'hA; a = 16'hF0F0; b = 16'h000A; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("srl_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_flags", flags, 0);
        do_op(4'h0, 16'h0001, 16'hFFFF, 0, r, f);
        check("post_rst_res", r, 16'h0000); check("post_rst_szcv", f, 4'b0110);

        do_op(4'h2, 16'hF0F0, 16'h3C3C, 0, r, f);
        do_op(4'h3, 16'hF000, 16'h000F, 1, r, f);
        do_op(4'h4, 16'hAAAA, 16'hAAAA, 0, r, f);
        do_op(4'h6, 16'h8000, 16'h1234, 0, r, f);
        do_op(4'h7, 16'h1234, 16'h5678, 0, r, f);
        check("illegal_szcv", f, 4'b0100);
        do_op(4'hF, 16'hFFFF, 16'hFFFF, 0, r, f);
        do_op(4'h1, 16'h0001, 16'h8000, 0, r, f);
        check("sub_ovf_szcv", f, 4'b0001);
        do_op(4'h0, 16'h8000, 16'h8000, 0, r, f);
        do_op(4'hA, 16'h00F1, 16'h0001, 0, r, f);
        do_op(4'hA, 16'hF0F0, 16'h000A, 2, r, f);
        do_op(4'hB, 16'h9001, 16'h0003, 0, r, f);
        do_op(4'h9, 16'h1235, 16'h000F, 0, r, f);
        do_op(4'h8, 16'h0001, 16'h0FFF, 0, r, f);
        do_op(4'h5, 16'h0009, 16'h0002, 0, r, f);

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
